// File: rtl/rs_issue_scheduler.sv
// Reservation-station occupancy/readiness controller: allocates free entries to dispatch slots
// and moves ready entries into a registered, handshaked issue stage.
module rs_issue_scheduler #(
  parameter int unsigned N       = 2,
  parameter int unsigned ENTRIES = 8,
  localparam int unsigned IDXW   = $clog2(ENTRIES)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                squash,
  input  logic [N-1:0]        disp_req,
  input  logic [N-1:0]        disp_rdy,
  output logic [N-1:0]        disp_gnt,
  output logic [N*IDXW-1:0]   disp_idx,
  output logic [IDXW:0]       free_count,
  input  logic [ENTRIES-1:0]  wake,
  output logic [N-1:0]        iss_valid,
  output logic [N*IDXW-1:0]   iss_idx,
  input  logic [N-1:0]        iss_ack
);

  typedef struct packed {
    logic            vld;
    logic [IDXW-1:0] idx;
  } pick_t;
  typedef pick_t [N-1:0] pick_vec_t;

  // Priority selector: even lines take the lowest remaining request, odd lines the highest.
  function automatic pick_vec_t prio_pick(input logic [ENTRIES-1:0] req);
    pick_vec_t        res;
    logic [ENTRIES-1:0] rem;
    rem = req;
    res = '0;
    for (int l = 0; l < N; l++) begin
      if (l % 2 == 0) begin
        for (int e = ENTRIES - 1; e >= 0; e--) begin
          if (rem[e]) begin
            res[l].vld = 1'b1;
            res[l].idx = IDXW'(e);
          end
        end
      end else begin
        for (int e = 0; e < ENTRIES; e++) begin
          if (rem[e]) begin
            res[l].vld = 1'b1;
            res[l].idx = IDXW'(e);
          end
        end
      end
      if (res[l].vld) rem[res[l].idx] = 1'b0;
    end
    return res;
  endfunction

  logic [ENTRIES-1:0]        valid_q, valid_d;
  logic [ENTRIES-1:0]        ready_q, ready_d;
  logic [ENTRIES-1:0]        issuing_q, issuing_d;
  logic [N-1:0]              iss_valid_q, iss_valid_d;
  logic [N-1:0][IDXW-1:0]    iss_idx_q, iss_idx_d;
  logic [IDXW:0]             free_count_q, free_count_d;

  pick_vec_t   free_pick, iss_pick;
  logic        gnt_chain;
  int unsigned open_cnt;

  assign free_pick = prio_pick(~valid_q);
  assign iss_pick  = prio_pick(valid_q & ready_q & ~issuing_q);

  // Grants form a prefix: a refused slot blocks every later slot.
  always_comb begin
    disp_gnt  = '0;
    disp_idx  = '0;
    gnt_chain = ~squash;
    for (int k = 0; k < N; k++) begin
      disp_gnt[k] = gnt_chain & disp_req[k] & free_pick[k].vld;
      gnt_chain   = disp_gnt[k];
      disp_idx[k*IDXW +: IDXW] = free_pick[k].idx;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    ready_d     = ready_q;
    issuing_d   = issuing_q;
    iss_valid_d = iss_valid_q;
    iss_idx_d   = iss_idx_q;
    open_cnt    = 0;
    if (squash) begin
      valid_d     = '0;
      ready_d     = '0;
      issuing_d   = '0;
      iss_valid_d = '0;
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (wake[e] && valid_q[e]) ready_d[e] = 1'b1;
      end
      // Ack after wake so a retiring entry never leaves with ready set.
      for (int k = 0; k < N; k++) begin
        if (iss_ack[k] && iss_valid_q[k]) begin
          valid_d[iss_idx_q[k]]   = 1'b0;
          ready_d[iss_idx_q[k]]   = 1'b0;
          issuing_d[iss_idx_q[k]] = 1'b0;
          iss_valid_d[k]          = 1'b0;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (disp_gnt[k]) begin
          valid_d[free_pick[k].idx]   = 1'b1;
          ready_d[free_pick[k].idx]   = disp_rdy[k];
          issuing_d[free_pick[k].idx] = 1'b0;
        end
      end
      // Open slots in ascending order consume selector lines 0, 1, ...
      for (int k = 0; k < N; k++) begin
        if (!iss_valid_q[k] || iss_ack[k]) begin
          for (int l = 0; l < N; l++) begin
            if (l == open_cnt && iss_pick[l].vld) begin
              iss_valid_d[k]               = 1'b1;
              iss_idx_d[k]                 = iss_pick[l].idx;
              issuing_d[iss_pick[l].idx]   = 1'b1;
            end
          end
          open_cnt = open_cnt + 1;
        end
      end
    end
    free_count_d = (IDXW+1)'(ENTRIES);
    for (int e = 0; e < ENTRIES; e++) begin
      free_count_d = free_count_d - (IDXW+1)'(valid_d[e]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      ready_q      <= '0;
      issuing_q    <= '0;
      iss_valid_q  <= '0;
      iss_idx_q    <= '0;
      free_count_q <= (IDXW+1)'(ENTRIES);
    end else begin
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      issuing_q    <= issuing_d;
      iss_valid_q  <= iss_valid_d;
      iss_idx_q    <= iss_idx_d;
      free_count_q <= free_count_d;
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_idx    = iss_idx_q;
  assign free_count = free_count_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler (N=2, ENTRIES=8); issued entries are tracked by an
// expected-order scoreboard queue.
module tb_rs_issue_scheduler;

  localparam int unsigned N       = 2;
  localparam int unsigned ENTRIES = 8;
  localparam int unsigned IDXW    = 3;

  logic                clock;
  logic                reset_n;
  logic                squash;
  logic [N-1:0]        disp_req;
  logic [N-1:0]        disp_rdy;
  logic [N-1:0]        disp_gnt;
  logic [N*IDXW-1:0]   disp_idx;
  logic [IDXW:0]       free_count;
  logic [ENTRIES-1:0]  wake;
  logic [N-1:0]        iss_valid;
  logic [N*IDXW-1:0]   iss_idx;
  logic [N-1:0]        iss_ack;

  int n_checks;
  int n_errors;
  int exp_iss_q[$];

  rs_issue_scheduler #(
    .N       (N),
    .ENTRIES (ENTRIES)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .squash     (squash),
    .disp_req   (disp_req),
    .disp_rdy   (disp_rdy),
    .disp_gnt   (disp_gnt),
    .disp_idx   (disp_idx),
    .free_count (free_count),
    .wake       (wake),
    .iss_valid  (iss_valid),
    .iss_idx    (iss_idx),
    .iss_ack    (iss_ack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int unsigned slot_idx(input logic [N*IDXW-1:0] v, input int k);
    return int'(v[k*IDXW +: IDXW]);
  endfunction

  // Pop the next expected issued entry and compare it against issue slot k.
  task automatic pop_issue(input int k, input string tag);
    int exp;
    check({tag, "_vld"}, int'(iss_valid[k]), 1);
    check({tag, "_sb"}, int'(exp_iss_q.size() != 0), 1);
    if (exp_iss_q.size() != 0) begin
      exp = exp_iss_q.pop_front();
      check(tag, slot_idx(iss_idx, k), exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    squash   = 1'b0;
    disp_req = '0;
    disp_rdy = '0;
    wake     = '0;
    iss_ack  = '0;
    #12;
    check("rst_iss_valid", int'(iss_valid), 0);
    check("rst_free", int'(free_count), 8);
    check("rst_gnt0", int'(disp_gnt), 0);
    reset_n = 1'b1;
    step();

    // First allocation: lowest and highest free entries.
    disp_req = 2'b11;
    #1;
    check("disp1_gnt", int'(disp_gnt), 3);
    check("disp1_idx0", slot_idx(disp_idx, 0), 0);
    check("disp1_idx1", slot_idx(disp_idx, 1), 7);
    step();
    disp_req = '0;
    check("disp1_free", int'(free_count), 6);

    // Wake latency and hold while not acked.
    wake = 8'h01;
    exp_iss_q.push_back(0);
    step();
    wake = '0;
    check("wake_t1_vld", int'(iss_valid), 0);
    step();
    pop_issue(0, "wake_iss0");
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_vld", int'(iss_valid), 1);
      check("hold_idx", slot_idx(iss_idx, 0), 0);
    end
    iss_ack = 2'b01;
    step();
    iss_ack = '0;
    check("ack_free", int'(free_count), 7);
    check("ack_vld", int'(iss_valid), 0);

    // Fill remaining entries pairwise, then the final single one.
    begin
      int lo[3] = '{0, 1, 2};
      int hi[3] = '{6, 5, 4};
      for (int i = 0; i < 3; i++) begin
        disp_req = 2'b11;
        #1;
        check("fill_gnt", int'(disp_gnt), 3);
        check("fill_idx0", slot_idx(disp_idx, 0), lo[i]);
        check("fill_idx1", slot_idx(disp_idx, 1), hi[i]);
        step();
      end
    end
    #1;
    check("last_gnt", int'(disp_gnt), 1);
    check("last_idx0", slot_idx(disp_idx, 0), 3);
    step();
    check("full_free", int'(free_count), 0);
    check("full_gnt", int'(disp_gnt), 0);
    disp_req = '0;

    // Two wakes land in both slots; ack only slot 0.
    wake = 8'h28;
    exp_iss_q.push_back(3);
    exp_iss_q.push_back(5);
    step();
    wake = '0;
    step();
    pop_issue(0, "pair_iss0");
    pop_issue(1, "pair_iss1");
    iss_ack = 2'b01;
    step();
    iss_ack = '0;
    check("pair_ack_vld", int'(iss_valid), 2);
    check("pair_hold_idx1", slot_idx(iss_idx, 1), 5);
    check("pair_ack_free", int'(free_count), 1);
    disp_req = 2'b11;
    #1;
    check("one_free_gnt", int'(disp_gnt), 1);
    check("one_free_idx0", slot_idx(disp_idx, 0), 3);
    disp_req = '0;
    iss_ack = 2'b10;
    step();
    iss_ack = '0;
    check("pair_ack2_free", int'(free_count), 2);
    check("pair_ack2_vld", int'(iss_valid), 0);

    // Four ready entries, both slots acked every cycle.
    wake = 8'h17;
    exp_iss_q.push_back(0);
    exp_iss_q.push_back(4);
    exp_iss_q.push_back(1);
    exp_iss_q.push_back(2);
    step();
    wake = '0;
    step();
    iss_ack = 2'b11;
    for (int i = 0; i < 2; i++) begin
      pop_issue(0, "tput_iss0");
      pop_issue(1, "tput_iss1");
      step();
    end
    iss_ack = '0;
    check("tput_drain_vld", int'(iss_valid), 0);
    check("tput_free", int'(free_count), 6);
    check("tput_sb_empty", exp_iss_q.size(), 0);

    // Squash with valid slots and pending wakes.
    wake = 8'hC0;
    exp_iss_q.push_back(6);
    exp_iss_q.push_back(7);
    step();
    wake = '0;
    step();
    pop_issue(0, "pre_sq_iss0");
    pop_issue(1, "pre_sq_iss1");
    disp_req = 2'b11;
    #1;
    check("pre_sq_idx1", slot_idx(disp_idx, 1), 5);
    step();
    squash = 1'b1;
    wake   = 8'h21;
    #1;
    check("sq_gnt", int'(disp_gnt), 0);
    step();
    squash   = 1'b0;
    wake     = '0;
    disp_req = '0;
    check("sq_vld", int'(iss_valid), 0);
    check("sq_free", int'(free_count), 8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_sq_vld", int'(iss_valid), 0);
    end
    disp_req = 2'b11;
    disp_rdy = 2'b11;
    #1;
    check("post_sq_gnt", int'(disp_gnt), 3);
    check("post_sq_idx1", slot_idx(disp_idx, 1), 7);
    step();
    disp_req = '0;
    disp_rdy = '0;
    check("post_sq_free", int'(free_count), 6);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_free", int'(free_count), 8);
    check("arst_vld", int'(iss_valid), 0);
    disp_req = 2'b11;
    #1;
    check("arst_gnt", int'(disp_gnt), 3);
    disp_req = '0;
    #1;
    reset_n = 1'b1;
    step();
    step();
    check("arst_after_vld", int'(iss_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
